wb_clint_arbiter: RTL and testbench

- Two-master to one-slave Wishbone arbiter that shares the memory-mapped machine-timer/software-interrupt register block between two masters.
- M0 is the core data port; M1 is the debug/DMA port.
- Single-beat transfers only, with round-robin fairness.
- Includes a no-ACK watchdog that terminates a hung transfer with ERR so neither master can stall the other.

---
 rtl/wb_clint_arbiter_pkg.sv | 20 ++
 rtl/wb_clint_arbiter_if.sv | 45 ++++
 rtl/wb_rr_picker.sv | 22 ++
 rtl/wb_clint_arbiter.sv | 115 +++++++++++
 tb/tb_wb_clint_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_clint_arbiter_pkg.sv
// Shared types and constants for the two-master CLINT Wishbone arbiter.
// Data width follows the core XLEN (64 when RV64I is defined, else 32).
package wb_clint_arbiter_pkg;

`ifdef RV64I
  localparam int DATA_SIZE = 64;
`else
  localparam int DATA_SIZE = 32;
`endif

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;

endpackage

// File: rtl/wb_clint_arbiter_if.sv
// Bundle of both master ports, the slave port and the grant vector.
// slave modport is the arbiter's view; master modport is the environment's view.
interface wb_clint_arbiter_if #(
  parameter int AddrWidth = 3
);
  import wb_clint_arbiter_pkg::*;

  logic                 M0_CYC_I, M0_STB_I, M0_WE_I;
  logic [AddrWidth-1:0] M0_ADR_I;
  logic [DATA_SIZE-1:0] M0_DAT_I, M0_DAT_O;
  logic                 M0_ACK_O, M0_ERR_O;

  logic                 M1_CYC_I, M1_STB_I, M1_WE_I;
  logic [AddrWidth-1:0] M1_ADR_I;
  logic [DATA_SIZE-1:0] M1_DAT_I, M1_DAT_O;
  logic                 M1_ACK_O, M1_ERR_O;

  logic                 S_CYC_O, S_STB_O, S_WE_O;
  logic [AddrWidth-1:0] S_ADR_O;
  logic [DATA_SIZE-1:0] S_DAT_O, S_DAT_I;
  logic                 S_ACK_I;

  logic [1:0]           GNT_O;

  modport slave (
    input  M0_CYC_I, M0_STB_I, M0_WE_I, M0_ADR_I, M0_DAT_I,
    output M0_DAT_O, M0_ACK_O, M0_ERR_O,
    input  M1_CYC_I, M1_STB_I, M1_WE_I, M1_ADR_I, M1_DAT_I,
    output M1_DAT_O, M1_ACK_O, M1_ERR_O,
    output S_CYC_O, S_STB_O, S_WE_O, S_ADR_O, S_DAT_O,
    input  S_DAT_I, S_ACK_I,
    output GNT_O
  );

  modport master (
    output M0_CYC_I, M0_STB_I, M0_WE_I, M0_ADR_I, M0_DAT_I,
    input  M0_DAT_O, M0_ACK_O, M0_ERR_O,
    output M1_CYC_I, M1_STB_I, M1_WE_I, M1_ADR_I, M1_DAT_I,
    input  M1_DAT_O, M1_ACK_O, M1_ERR_O,
    input  S_CYC_O, S_STB_O, S_WE_O, S_ADR_O, S_DAT_O,
    output S_DAT_I, S_ACK_I,
    input  GNT_O
  );

endinterface

// File: rtl/wb_rr_picker.sv
// Combinational 2-way round-robin picker: one-hot grant, zero latency.
// On contention the master that did not win last time is chosen.
module wb_rr_picker
  import wb_clint_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = GNT_NONE;
    if (&req_i) begin
      gnt_o = last_grant_i ? GNT_M0 : GNT_M1;
    end else if (req_i[0]) begin
      gnt_o = GNT_M0;
    end else if (req_i[1]) begin
      gnt_o = GNT_M1;
    end
  end

endmodule

// File: rtl/wb_clint_arbiter.sv
// Two-master round-robin Wishbone arbiter with no-ACK watchdog for the CLINT block.
// Request to S_CYC_O is one cycle; ACK/ERR return combinationally; one IDLE bubble between transfers.
module wb_clint_arbiter
  import wb_clint_arbiter_pkg::*;
#(
  parameter int AddrWidth     = 3,
  parameter int TimeoutCycles = 16
) (
  input logic              CLK_I,
  input logic              RST_NI,
  wb_clint_arbiter_if.slave bus
);

  localparam int              CntW    = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);
  localparam bit              WdogEn  = (TimeoutCycles != 0);

  state_e               state_q, state_d;
  logic [1:0]           grant_q, grant_d;
  logic                 last_q, last_d;
  logic [CntW-1:0]      cnt_q, cnt_d;

  logic [1:0]           req, pick;
  logic                 gidx, g_cyc, g_stb, g_we, tmo_hit;
  logic [AddrWidth-1:0] g_adr;
  logic [DATA_SIZE-1:0] g_dat;

  assign req = {bus.M1_CYC_I & bus.M1_STB_I, bus.M0_CYC_I & bus.M0_STB_I};

  wb_rr_picker u_picker (
    .req_i       (req),
    .last_grant_i(last_q),
    .gnt_o       (pick)
  );

  assign gidx  = grant_q[1];
  assign g_cyc = gidx ? bus.M1_CYC_I : bus.M0_CYC_I;
  assign g_stb = gidx ? bus.M1_STB_I : bus.M0_STB_I;
  assign g_we  = gidx ? bus.M1_WE_I  : bus.M0_WE_I;
  assign g_adr = gidx ? bus.M1_ADR_I : bus.M0_ADR_I;
  assign g_dat = gidx ? bus.M1_DAT_I : bus.M0_DAT_I;

  // ACK takes precedence: the watchdog only fires on a cycle without ACK.
  assign tmo_hit = WdogEn && (state_q == ST_BUSY) && g_cyc && !bus.S_ACK_I && (cnt_q == CntLast);

  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      state_q <= ST_IDLE;
      grant_q <= GNT_NONE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (|req) begin
          state_d = ST_BUSY;
          grant_d = pick;
        end
      end
      ST_BUSY: begin
        // ACK, watchdog expiry or the owner dropping CYC all end the transfer.
        if (bus.S_ACK_I || !g_cyc || tmo_hit) begin
          state_d = ST_IDLE;
          grant_d = GNT_NONE;
          last_d  = gidx;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.S_CYC_O  = 1'b0;
    bus.S_STB_O  = 1'b0;
    bus.S_WE_O   = 1'b0;
    bus.S_ADR_O  = '0;
    bus.S_DAT_O  = '0;
    bus.M0_ACK_O = 1'b0;
    bus.M0_ERR_O = 1'b0;
    bus.M1_ACK_O = 1'b0;
    bus.M1_ERR_O = 1'b0;
    if (state_q == ST_BUSY) begin
      bus.S_CYC_O  = g_cyc;
      bus.S_STB_O  = g_cyc & g_stb;
      bus.S_WE_O   = g_we;
      bus.S_ADR_O  = g_adr;
      bus.S_DAT_O  = g_dat;
      bus.M0_ACK_O = ~gidx & bus.S_ACK_I & bus.M0_CYC_I;
      bus.M1_ACK_O =  gidx & bus.S_ACK_I & bus.M1_CYC_I;
      bus.M0_ERR_O = ~gidx & tmo_hit;
      bus.M1_ERR_O =  gidx & tmo_hit;
    end
  end

  assign bus.M0_DAT_O = bus.S_DAT_I;
  assign bus.M1_DAT_O = bus.S_DAT_I;
  assign bus.GNT_O    = grant_q;

endmodule

// File: tb/tb_wb_clint_arbiter.sv
// Bench for wb_clint_arbiter: two master BFMs and a slave model fed from a
// transaction-level round-robin model; a monitor scores every ACK/ERR against a queue.
module tb_wb_clint_arbiter;
  import wb_clint_arbiter_pkg::*;

  localparam int AW = 3;
  localparam int TO = 16;
  localparam int DW = DATA_SIZE;

  typedef struct {
    int             m;
    bit             we;
    logic [AW-1:0]  adr;
    logic [DW-1:0]  wdat;
    logic [DW-1:0]  rdat;
    int             lat;   // BUSY cycle index of slave ACK, -1 = never
    int             hold;  // cycles the slave keeps ACK high
    int             abrt;  // master drops CYC after this many cycles, -1 = never
  } txn_t;

  typedef struct {
    int            m;
    bit            err;
    bit            chk_dat;
    logic [DW-1:0] rdat;
    int            cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_clint_arbiter_if #(.AddrWidth(AW)) bus ();

  wb_clint_arbiter #(.AddrWidth(AW), .TimeoutCycles(TO)) dut (
    .CLK_I (clk),
    .RST_NI(rst_n),
    .bus   (bus)
  );

  logic [1:0]    m_cyc, m_stb, m_we, m_act;
  logic [AW-1:0] m_adr [2];
  logic [DW-1:0] m_dat [2];
  logic          s_ack;
  logic [DW-1:0] s_dat;

  assign bus.M0_CYC_I = m_cyc[0];
  assign bus.M0_STB_I = m_stb[0];
  assign bus.M0_WE_I  = m_we[0];
  assign bus.M0_ADR_I = m_adr[0];
  assign bus.M0_DAT_I = m_dat[0];
  assign bus.M1_CYC_I = m_cyc[1];
  assign bus.M1_STB_I = m_stb[1];
  assign bus.M1_WE_I  = m_we[1];
  assign bus.M1_ADR_I = m_adr[1];
  assign bus.M1_DAT_I = m_dat[1];
  assign bus.S_ACK_I  = s_ack;
  assign bus.S_DAT_I  = s_dat;

  txn_t mq0[$], mq1[$], st0[$], st1[$], plan_q[$];
  exp_t sb_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   last_m = 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic txn_t mk(input bit we, input int adr, input logic [DW-1:0] wdat,
                              input logic [DW-1:0] rdat, input int lat, input int hold,
                              input int abrt);
    txn_t t;
    t.m = 0; t.we = we; t.adr = AW'(adr); t.wdat = wdat; t.rdat = rdat;
    t.lat = lat; t.hold = hold; t.abrt = abrt;
    return t;
  endfunction

  // Reference model: serve pending masters round-robin, then derive each outcome.
  task automatic launch();
    int   i = 0;
    int   j = 0;
    int   pick;
    txn_t t;
    exp_t e;
    while (i < st0.size() || j < st1.size()) begin
      if (i < st0.size() && j < st1.size()) pick = (last_m == 0) ? 1 : 0;
      else pick = (i < st0.size()) ? 0 : 1;
      if (pick == 0) begin t = st0[i]; i++; end
      else begin t = st1[j]; j++; end
      t.m = pick;
      plan_q.push_back(t);
      if (t.abrt < 0) begin
        e.m       = pick;
        e.err     = (t.lat < 0) || (t.lat > TO - 1);
        e.cyc     = e.err ? TO - 1 : t.lat;
        e.chk_dat = !t.we && !e.err;
        e.rdat    = t.rdat;
        sb_q.push_back(e);
      end
      last_m = pick;
    end
    @(posedge clk); #1;
    foreach (st0[k]) begin t = st0[k]; t.m = 0; mq0.push_back(t); end
    foreach (st1[k]) begin t = st1[k]; t.m = 1; mq1.push_back(t); end
    st0.delete();
    st1.delete();
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((sb_q.size() != 0 || mq0.size() != 0 || mq1.size() != 0 || m_act != 2'b00) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_completes"}, 64'(n < 400), 1);
    chk({name, "_plans_used"}, 64'(plan_q.size()), 0);
    if (n >= 400) begin
      sb_q.delete(); mq0.delete(); mq1.delete(); plan_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #4 rst_n = 1'b1;
    last_m = 1;
    repeat (2) @(negedge clk);
  endtask

  // Master BFMs: one transaction at a time, released on own ACK/ERR, abort or reset.
  initial begin
    logic [1:0] term;
    txn_t       m_cur [2];
    int         m_cnt [2];
    txn_t       t;
    bit         has;
    m_cyc = '0; m_stb = '0; m_we = '0; m_act = '0;
    m_adr[0] = '0; m_adr[1] = '0; m_dat[0] = '0; m_dat[1] = '0;
    forever begin
      @(negedge clk);
      term = {bus.M1_ACK_O | bus.M1_ERR_O, bus.M0_ACK_O | bus.M0_ERR_O};
      @(posedge clk); #2;
      for (int m = 0; m < 2; m++) begin
        if (!rst_n) m_act[m] = 1'b0;
        else if (m_act[m]) begin
          if (term[m]) m_act[m] = 1'b0;
          else begin
            m_cnt[m]++;
            if (m_cur[m].abrt >= 0 && m_cnt[m] == m_cur[m].abrt) m_act[m] = 1'b0;
          end
        end
        if (!m_act[m] && rst_n) begin
          has = 1'b0;
          if (m == 0 && mq0.size() > 0) begin t = mq0.pop_front(); has = 1'b1; end
          if (m == 1 && mq1.size() > 0) begin t = mq1.pop_front(); has = 1'b1; end
          if (has) begin
            m_cur[m] = t; m_cnt[m] = 0; m_act[m] = 1'b1;
            m_cyc[m] = 1'b1; m_stb[m] = 1'b1; m_we[m] = t.we;
            m_adr[m] = t.adr; m_dat[m] = t.wdat;
          end
        end
        if (!m_act[m]) begin
          m_cyc[m] = 1'b0; m_stb[m] = 1'b0; m_we[m] = 1'($urandom);
          m_adr[m] = AW'($urandom); m_dat[m] = DW'($urandom);
        end
      end
    end
  end

  // Slave model: checks the forwarded request, then ACKs per the transaction plan.
  initial begin
    bit   sl_act = 1'b0;
    int   sl_idx = 0;
    int   sticky = 0;
    txn_t sp;
    s_ack = 1'b0;
    s_dat = '0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        sl_act = 1'b0; sticky = 0; s_ack = 1'b0;
      end else begin
        if (sl_act && !bus.S_CYC_O) sl_act = 1'b0;
        if (!sl_act && bus.S_CYC_O) begin
          sticky = 0;
          chk("xfer_planned", 64'(plan_q.size() != 0), 1);
          if (plan_q.size() != 0) begin
            sp = plan_q.pop_front();
            sl_act = 1'b1;
            sl_idx = 0;
            chk("start_gnt", bus.GNT_O, (sp.m == 1) ? 2'b10 : 2'b01);
            chk("start_stb", bus.S_STB_O, 1);
            chk("start_we", bus.S_WE_O, sp.we);
            chk("start_adr", bus.S_ADR_O, sp.adr);
            if (sp.we) chk("start_wdat", bus.S_DAT_O, sp.wdat);
          end
        end else if (sl_act) begin
          sl_idx++;
        end
        if (sl_act && sp.lat >= 0 && sl_idx == sp.lat) begin
          s_ack = 1'b1; s_dat = sp.rdat; sticky = sp.hold - 1;
        end else if (sticky > 0) begin
          sticky--; s_ack = 1'b1;
        end else begin
          s_ack = 1'b0; s_dat = DW'($urandom);
        end
      end
    end
  end

  // Monitor: every ACK/ERR pops the next expected termination.
  initial begin
    bit         prev = 1'b0;
    int         idx = 0;
    logic [3:0] t, exp4;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (!rst_n) prev = 1'b0;
      else begin
        if (bus.S_CYC_O) idx = prev ? idx + 1 : 0;
        prev = bus.S_CYC_O;
        t = {bus.M1_ERR_O, bus.M1_ACK_O, bus.M0_ERR_O, bus.M0_ACK_O};
        if (t != 4'b0000) begin
          if (sb_q.size() == 0) chk("unexpected_term", t, 0);
          else begin
            e = sb_q.pop_front();
            exp4 = (e.m == 1) ? (e.err ? 4'b1000 : 4'b0100) : (e.err ? 4'b0010 : 4'b0001);
            chk("term_flags", t, exp4);
            chk("term_cycle", idx, e.cyc);
            chk("term_gnt", bus.GNT_O, (e.m == 1) ? 2'b10 : 2'b01);
            if (e.chk_dat) chk("rdata", (e.m == 1) ? bus.M1_DAT_O : bus.M0_DAT_O, e.rdat);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    int n0, n1, r, lat;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cyc", bus.S_CYC_O, 0);
    chk("rst_stb", bus.S_STB_O, 0);
    chk("rst_gnt", bus.GNT_O, 0);
    chk("rst_ackerr", {bus.M0_ACK_O, bus.M0_ERR_O, bus.M1_ACK_O, bus.M1_ERR_O}, 0);
    chk("rst_adrdat", {bus.S_WE_O, bus.S_ADR_O, bus.S_DAT_O}, 0);
    @(posedge clk); #4 rst_n = 1'b1;
    last_m = 1;
    repeat (2) @(negedge clk);

    // Single M0 read, slave ACKs two cycles after S_CYC_O.
    st0.push_back(mk(0, 2, '0, DW'(32'h1234), 2, 1, -1));
    launch();
    @(negedge clk); chk("lat_idle_cyc", bus.S_CYC_O, 0);
    @(negedge clk); chk("lat_busy_cyc", bus.S_CYC_O, 1); chk("lat_busy_gnt", bus.GNT_O, 2'b01);
    wait_done("single_read");
    chk("single_gnt_after", bus.GNT_O, 0);

    // Contention from reset: order must alternate 0,1,0,1.
    apply_reset();
    for (int k = 0; k < 2; k++) begin
      st0.push_back(mk(1, k, DW'($urandom), '0, 1, 1, -1));
      st1.push_back(mk(1, 4 + k, DW'($urandom), '0, 0, 1, -1));
    end
    launch();
    wait_done("contention");

    // M1 read never ACKed: ERR after 16 BUSY cycles, then M0 is served.
    st0.push_back(mk(0, 1, '0, DW'($urandom), 0, 1, -1));
    launch();
    wait_done("pre_timeout");
    st0.push_back(mk(0, 3, '0, DW'($urandom), 1, 1, -1));
    st1.push_back(mk(0, 5, '0, DW'($urandom), -1, 1, -1));
    launch();
    wait_done("timeout");

    // ACK on the last watchdog cycle wins.
    st1.push_back(mk(0, 6, '0, DW'($urandom), TO - 1, 1, -1));
    launch();
    wait_done("ack_tie");

    // M0 drops CYC in its second BUSY cycle.
    st0.push_back(mk(0, 7, '0, '0, -1, 1, 2));
    launch();
    @(negedge clk);
    @(negedge clk); chk("abort_gnt_busy", bus.GNT_O, 2'b01);
    @(negedge clk); chk("abort_cyc_gated", bus.S_CYC_O, 0);
    @(negedge clk); chk("abort_idle", bus.GNT_O, 0);
    wait_done("abort");

    // Asynchronous reset in the middle of a BUSY transfer.
    st0.push_back(mk(0, 2, '0, '0, -1, 1, 1000));
    launch();
    repeat (3) @(negedge clk);
    @(posedge clk); #3 rst_n = 1'b0;
    #1 chk("midrst_outputs", {bus.S_CYC_O, bus.S_STB_O, bus.S_WE_O, bus.GNT_O,
                              bus.M0_ACK_O, bus.M0_ERR_O, bus.M1_ACK_O, bus.M1_ERR_O}, 0);
    @(posedge clk); #4 rst_n = 1'b1;
    last_m = 1;
    wait_done("mid_reset");
    st0.push_back(mk(0, 1, '0, DW'($urandom), 1, 1, -1));
    st1.push_back(mk(0, 2, '0, DW'($urandom), 1, 1, -1));
    launch();
    wait_done("post_reset_contention");

    // Sticky slave ACK spills into the IDLE bubble before M1's transfer.
    st0.push_back(mk(0, 4, '0, DW'($urandom), 1, 3, -1));
    st1.push_back(mk(0, 5, '0, DW'($urandom), 2, 1, -1));
    launch();
    wait_done("sticky_ack");

    // Randomised batches with mixed latencies, ties and timeouts.
    for (int b = 0; b < 25; b++) begin
      n0 = $urandom_range(0, 3);
      n1 = $urandom_range(0, 3);
      if (n0 == 0 && n1 == 0) n0 = 1;
      for (int k = 0; k < n0 + n1; k++) begin
        r = $urandom_range(0, 9);
        lat = (r == 0) ? -1 : (r == 1) ? TO - 1 : (r == 2) ? TO : $urandom_range(0, 4);
        if (k < n0) st0.push_back(mk(1'($urandom), $urandom_range(0, 7), DW'($urandom), DW'($urandom),
                                     lat, $urandom_range(1, 3), -1));
        else        st1.push_back(mk(1'($urandom), $urandom_range(0, 7), DW'($urandom), DW'($urandom),
                                     lat, $urandom_range(1, 3), -1));
      end
      launch();
      wait_done("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
